pll_lock_sequencer: RTL
=======================

// Module: pll_lock_sequencer
// PURPOSE
//  Sequences the PLL bring-up: pulses the PLL reset, waits for lock with a timeout and retry,
//  and requires lock to stay stable before releasing the downstream reset.
//  On loss of lock it counts the event and re-runs the sequence.
//  Sits between the board reset and the PLL block; its sys_rst_o gates all PLL-output clock domains.
// PARAMETERS
//  RST_PULSE_CYCLES     16      refclk cycles pll_rst_o held high per attempt (>=1)
//  LOCK_TIMEOUT_CYCLES  100000  max cycles in WAIT_LOCK before a retry (1 ms @ 100 MHz)
//  LOCK_STABLE_CYCLES   1024    consecutive synced-lock cycles required before RUN (>=1)
//  MAX_RETRIES          4       PLL reset attempts before FAIL (>=1)
//  CNT_W                20      shared cycle-counter width; must hold max of the three cycle params
// PORTS
//  refclk           in   1  free-running reference clock, 100 MHz; sole clock
//  rst              in   1  synchronous, active-high reset
//  pll_locked_i     in   1  PLL locked, asynchronous; 2-flop synchronised internally -> locked_s
//  force_reset_i    in   1  single-cycle request to re-run the sequence (software/control path)
//  pll_rst_o        out  1  reset to PLL
//  sys_rst_o        out  1  downstream reset; high unless state==RUN
//  ready_o          out  1  high iff state==RUN
//  fail_o           out  1  high iff state==FAIL
//  state_o          out  3  RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4
//  retry_cnt_o      out  3  attempts consumed in the current bring-up
//  lock_loss_cnt_o  out  8  number of RUN->lock-lost events, saturating at 255
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=RESET_PLL, cnt=0, retry=0, lock_loss=0, sync flops=0.
//   Outputs: pll_rst_o=1, sys_rst_o=1, ready_o=0, fail_o=0.
//   rst mid-sequence aborts immediately to this state.
//  All outputs are registered or decoded from the registered state. No combinational input->output path.
//  locked_s = pll_locked_i delayed by exactly 2 refclk cycles.
//  State transitions (cnt clears on every state change):
//   RESET_PLL: pll_rst_o=1.
//     If cnt==RST_PULSE_CYCLES-1, go to WAIT_LOCK; otherwise cnt++.
//     The pulse is exactly RST_PULSE_CYCLES cycles.
//   WAIT_LOCK: pll_rst_o=0.
//     If locked_s=1, go to STABLE.
//     Else if cnt==LOCK_TIMEOUT_CYCLES-1:
//       if retry==MAX_RETRIES-1, go to FAIL;
//       otherwise retry++ and go to RESET_PLL.
//     Else cnt++.
//   STABLE: if locked_s=0, go back to WAIT_LOCK.
//     The timeout restarts from 0 and this is not counted as a retry.
//     Else if cnt==LOCK_STABLE_CYCLES-1, go to RUN and clear retry.
//     Else cnt++.
//   RUN: sys_rst_o=0, ready_o=1.
//     If locked_s=0: lock_loss++ (saturating at 255) and go to RESET_PLL.
//     sys_rst_o goes high the cycle after locked_s is seen low.
//   FAIL: pll_rst_o=1, fail_o=1.
//     Terminal; exit only via rst or force_reset_i.
//  force_reset_i=1 in any state: go to RESET_PLL with cnt=0 and retry=0. lock_loss is unchanged.
//   It has priority over every lock or timeout event in that same cycle.
//   If it coincides with a RUN lock-loss, lock_loss is still incremented.
//  force_reset_i held high keeps the block in RESET_PLL with cnt held at 0.
//  Counter width: CNT_W must hold every cycle parameter. Compares are equality on cnt. No wrap is reachable.
//  retry_cnt_o is 3 bits, so MAX_RETRIES<=8.
// TESTING  (params RST_PULSE=4, TIMEOUT=32, STABLE=8, MAX_RETRIES=2)
//  1. Release rst, raise pll_locked_i at cycle 10 and hold.
//     -> pll_rst_o high for cycles 0-3.
//     -> ready_o rises 8 cycles after locked_s first high; sys_rst_o=0 from then; retry_cnt_o=0.
//  2. Keep pll_locked_i=0.
//     -> two 4-cycle pll_rst_o pulses, each followed by a 32-cycle wait.
//     -> then fail_o=1, pll_rst_o=1, state_o=4; these stay static for 200 cycles.
//  3. In RUN, drop pll_locked_i for 1 cycle.
//     -> sys_rst_o=1 and lock_loss_cnt_o=1 three cycles later; a new bring-up completes.
//     -> repeat 300 times: lock_loss_cnt_o saturates at 255.
//  4. In STABLE, glitch lock low at stable count 5.
//     -> state returns to WAIT_LOCK; retry_cnt_o is unchanged.
//     -> after relock, the full 8 stable cycles are required again.
//  5. Pulse force_reset_i in FAIL, and in RUN on the same cycle locked_s falls.
//     -> RESET_PLL with retry_cnt_o=0; lock_loss increments only in the RUN case.
//  6. Assert rst mid-WAIT_LOCK with retry=1.
//     -> next cycle all outputs are at reset values and lock_loss_cnt_o=0.

Source files
------------

// File: rtl/pll_lock_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : pll_lock_sequencer_if
//  Purpose  : Control/status bundle between the PLL lock sequencer and its user.
//  Revision : 1.0  initial release
// ============================================================================
interface pll_lock_sequencer_if;
    logic       pll_locked_i;
    logic       force_reset_i;
    logic       pll_rst_o;
    logic       sys_rst_o;
    logic       ready_o;
    logic       fail_o;
    logic [2:0] state_o;
    logic [2:0] retry_cnt_o;
    logic [7:0] lock_loss_cnt_o;

    modport master (
        output pll_locked_i, force_reset_i,
        input  pll_rst_o, sys_rst_o, ready_o, fail_o, state_o, retry_cnt_o, lock_loss_cnt_o
    );

    modport slave (
        input  pll_locked_i, force_reset_i,
        output pll_rst_o, sys_rst_o, ready_o, fail_o, state_o, retry_cnt_o, lock_loss_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pll_lock_sequencer
//  Purpose  : PLL bring-up sequencer: reset pulse, lock wait with timeout/retry,
//             lock stability qualification, downstream reset release.
//  Revision : 1.0  initial release
// ============================================================================
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 4,
    parameter int CNT_W               = 20
) (
    input  wire logic           refclk,
    input  wire logic           rst,
    pll_lock_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_pulse_last   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_stable_last  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one      = CNT_W'(1);
    localparam logic [2:0]       c_retry_last   = 3'(MAX_RETRIES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_retry;
    logic [7:0]       r_lock_loss;
    logic             r_sync1;
    logic             r_sync2;
    logic [3:0]       r_outs;      // {pll_rst, sys_rst, ready, fail}
    logic             w_locked_s;
    logic             w_lost;

    // Output pattern for the state being entered, registered alongside the state
    function automatic logic [3:0] f_outs(input state_t s);
        case (s)
            S_RESET_PLL: f_outs = 4'b1100;
            S_WAIT_LOCK: f_outs = 4'b0100;
            S_STABLE:    f_outs = 4'b0100;
            S_RUN:       f_outs = 4'b0010;
            S_FAIL:      f_outs = 4'b1101;
            default:     f_outs = 4'b1100;
        endcase
    endfunction

    assign w_locked_s = r_sync2;
    assign w_lost     = (r_state == S_RUN) && !w_locked_s;

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_state     <= S_RESET_PLL;
            r_outs      <= f_outs(S_RESET_PLL);
            r_cnt       <= '0;
            r_retry     <= '0;
            r_lock_loss <= '0;
        end else begin
            r_sync1 <= bus.pll_locked_i;
            r_sync2 <= r_sync1;

            // Lock-loss is counted even when a forced restart wins the same cycle
            if (w_lost && (r_lock_loss != 8'hFF)) begin
                r_lock_loss <= r_lock_loss + 8'd1;
            end

            if (bus.force_reset_i) begin
                r_state <= S_RESET_PLL;
                r_outs  <= f_outs(S_RESET_PLL);
                r_cnt   <= '0;
                r_retry <= '0;
            end else begin
                case (r_state)
                    S_RESET_PLL: begin
                        if (r_cnt == c_pulse_last) begin
                            r_state <= S_WAIT_LOCK;
                            r_outs  <= f_outs(S_WAIT_LOCK);
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_one;
                        end
                    end
                    S_WAIT_LOCK: begin
                        if (w_locked_s) begin
                            r_state <= S_STABLE;
                            r_outs  <= f_outs(S_STABLE);
                            r_cnt   <= '0;
                        end else if (r_cnt == c_timeout_last) begin
                            r_cnt <= '0;
                            if (r_retry == c_retry_last) begin
                                r_state <= S_FAIL;
                                r_outs  <= f_outs(S_FAIL);
                            end else begin
                                r_retry <= r_retry + 3'd1;
                                r_state <= S_RESET_PLL;
                                r_outs  <= f_outs(S_RESET_PLL);
                            end
                        end else begin
                            r_cnt <= r_cnt + c_cnt_one;
                        end
                    end
                    S_STABLE: begin
                        // A glitch restarts the lock wait without consuming a retry
                        if (!w_locked_s) begin
                            r_state <= S_WAIT_LOCK;
                            r_outs  <= f_outs(S_WAIT_LOCK);
                            r_cnt   <= '0;
                        end else if (r_cnt == c_stable_last) begin
                            r_state <= S_RUN;
                            r_outs  <= f_outs(S_RUN);
                            r_cnt   <= '0;
                            r_retry <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_one;
                        end
                    end
                    S_RUN: begin
                        if (!w_locked_s) begin
                            r_state <= S_RESET_PLL;
                            r_outs  <= f_outs(S_RESET_PLL);
                            r_cnt   <= '0;
                        end
                    end
                    S_FAIL: begin
                        r_outs <= f_outs(S_FAIL);
                    end
                    default: begin
                        r_state <= S_RESET_PLL;
                        r_outs  <= f_outs(S_RESET_PLL);
                        r_cnt   <= '0;
                        r_retry <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.pll_rst_o       = r_outs[3];
    assign bus.sys_rst_o       = r_outs[2];
    assign bus.ready_o         = r_outs[1];
    assign bus.fail_o          = r_outs[0];
    assign bus.state_o         = r_state;
    assign bus.retry_cnt_o     = r_retry;
    assign bus.lock_loss_cnt_o = r_lock_loss;
endmodule
`default_nettype wire
